multizone_irrigation_ctrl: RTL and testbench
============================================

MULTIZONE_IRRIGATION_CTRL -- requirements
Module: multizone_irrigation_ctrl

Interface
REQ-001 Parameter N_ZONES, 4, number of valve zones (1..16).
REQ-002 Parameter DATA_W, 12, turbidity sample width.
REQ-003 Parameter CLK_HZ, 25000000, clock frequency in Hz.
REQ-004 Parameter THR_HI, 12, turbidity at or above which the long irrigation is used.
REQ-005 Parameter THR_LO, 8, turbidity at or above which the short irrigation is used.
REQ-006 Parameter T_HI_S, 10, long irrigation in seconds; T_LO_S, 5, short irrigation in seconds.
REQ-007 Parameter TIMEOUT_CYC, 2500000, maximum wait for a sample, in cycles.
REQ-008 clk  in  1  clock; reset is reset, asynchronous, active-high; clock clk.
REQ-009 reset  in  1  asynchronous active-high reset.
REQ-010 zone_enable  in  N_ZONES  per-zone enable mask, sampled every cycle.
REQ-011 sample_data  in  DATA_W  turbidity value from the ESP32.
REQ-012 sample_valid  in  1  sample_data is valid this cycle.
REQ-013 sample_req  out  1  request for a sample of zone zone_sel.
REQ-014 zone_sel  out  max(1,clog2(N_ZONES))  zone currently served.
REQ-015 valve  out  N_ZONES  one-hot valve drive, active-high.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 timeout_pulse  out  1  one-cycle pulse when a sample wait times out.

Function
REQ-018 The FSM SHALL have the states IDLE, SCAN, REQ, RUN, and ADV.
REQ-019 IDLE: when any zone_enable bit is set, the FSM SHALL go to SCAN next cycle; otherwise it SHALL stay in IDLE.
REQ-020 SCAN: the FSM SHALL load zone_sel with the first enabled zone found round-robin, starting at the zone after the last one served (zone 0 after reset), then go to REQ; with no zone enabled it SHALL return to IDLE.
REQ-021 REQ: sample_req SHALL be high on every cycle in REQ and low in all other states; sample_valid outside REQ SHALL be ignored.
REQ-022 When sample_valid is high in REQ, the block SHALL capture sample_data and compute dur = T_HI_S*CLK_HZ if the sample is >= THR_HI, else T_LO_S*CLK_HZ if >= THR_LO, else 0.
REQ-023 After that capture, the FSM SHALL go to RUN if dur is nonzero, otherwise to ADV.
REQ-024 Threshold compares SHALL be unsigned at DATA_W bits; duration arithmetic SHALL be 32-bit unsigned.
REQ-025 If REQ lasts TIMEOUT_CYC cycles without sample_valid, the block SHALL pulse timeout_pulse for one cycle and go to ADV.
REQ-026 RUN: valve[zone_sel] SHALL be high for exactly dur consecutive cycles, starting the cycle after the capture; all other valve bits SHALL be 0.
REQ-027 If zone_enable[zone_sel] falls during RUN, the valve SHALL close the next cycle and the FSM SHALL go to ADV.
REQ-028 ADV: the block SHALL record zone_sel as the last zone served and go to SCAN.
REQ-029 At most one valve bit SHALL be high in any cycle.
REQ-030 If the last zone served is N_ZONES-1, the next scan SHALL wrap to zone 0.

Reset
REQ-031 On reset, the FSM SHALL enter IDLE and valve, sample_req, timeout_pulse, busy, zone_sel, the counters, and the last-served pointer SHALL all be 0.
REQ-032 Reset during RUN SHALL close the valve immediately (asynchronously).

Structure
REQ-033 The state enum and the second-to-cycle conversion constants SHALL live in a shared package, irrigation_pkg.
REQ-034 The round-robin next-enabled-zone search SHALL be a combinational sub-module, zone_rr_arbiter.
REQ-035 The block SHALL have one 32-bit shared counter, used for the timeout in REQ and for the duration in RUN.

Verification (all scenarios run with CLK_HZ=10, TIMEOUT_CYC=20)
REQ-036 zone_enable=4'b0001, sample 15 -> valve=4'b0001 high for exactly 100 cycles, then a new request for zone 0.
REQ-037 zone_enable=4'b1010, samples 9 then 3 -> zone 1 valve high for 50 cycles; zone 3 gets no valve activity; next request is for zone 1.
REQ-038 zone_enable=4'b0100, no sample_valid -> timeout_pulse on cycle 20 of REQ, valve stays 0, re-request for zone 2.
REQ-039 Zone 0 running with sample 12, zone_enable[0] cleared at cycle 30 -> valve[0] is 0 by cycle 31 and the next enabled zone is served.
REQ-040 Reset asserted mid-RUN -> all outputs 0 at once; after release, the first request is for the lowest enabled zone.
REQ-041 sample_valid pulsed while in IDLE or RUN -> no change to state, duration, or outputs.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared types and constants for the multizone irrigation controller:
// FSM state encoding and second-to-cycle conversion.
package irrigation_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ,
    RUN,
    ADV
  } state_t;

  localparam int unsigned DEFAULT_CLK_HZ = 25_000_000;
  localparam int unsigned DEFAULT_T_HI_S = 10;
  localparam int unsigned DEFAULT_T_LO_S = 5;

  // Irrigation length in clock cycles, 32-bit unsigned.
  function automatic logic [31:0] sec_to_cyc(input int unsigned sec,
                                             input int unsigned clk_hz);
    return 32'(sec * clk_hz);
  endfunction

endpackage

// File: rtl/zone_rr_arbiter.sv
// Combinational round-robin search: first enabled zone at or after 'start',
// wrapping past the last zone back to zone 0.
module zone_rr_arbiter #(
  parameter int unsigned N_ZONES = 4,
  parameter int unsigned ZW      = 2
) (
  input  logic [N_ZONES-1:0] enable,
  input  logic [ZW-1:0]      start,
  output logic               found,
  output logic [ZW-1:0]      zone
);

  function automatic int unsigned wrap_idx(input int unsigned base,
                                           input int unsigned offset);
    return (base + offset) % N_ZONES;
  endfunction

  always_comb begin
    found = 1'b0;
    zone  = '0;
    for (int unsigned i = 0; i < N_ZONES; i++) begin
      if (!found && enable[ZW'(wrap_idx(32'(start), i))]) begin
        found = 1'b1;
        zone  = ZW'(wrap_idx(32'(start), i));
      end
    end
  end

endmodule

// File: rtl/multizone_irrigation_ctrl.sv
// Multizone irrigation controller: serves enabled zones round-robin, requests a
// turbidity sample per zone and opens that zone's valve for a sample-derived time.
module multizone_irrigation_ctrl
  import irrigation_pkg::*;
#(
  parameter int unsigned N_ZONES     = 4,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned CLK_HZ      = DEFAULT_CLK_HZ,
  parameter int unsigned THR_HI      = 12,
  parameter int unsigned THR_LO      = 8,
  parameter int unsigned T_HI_S      = DEFAULT_T_HI_S,
  parameter int unsigned T_LO_S      = DEFAULT_T_LO_S,
  parameter int unsigned TIMEOUT_CYC = 2_500_000,
  localparam int unsigned ZW         = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_ZONES-1:0] zone_enable,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_req,
  output logic [ZW-1:0]     zone_sel,
  output logic [N_ZONES-1:0] valve,
  output logic              busy,
  output logic              timeout_pulse
);

  localparam logic [31:0]       DUR_HI   = sec_to_cyc(T_HI_S, CLK_HZ);
  localparam logic [31:0]       DUR_LO   = sec_to_cyc(T_LO_S, CLK_HZ);
  localparam logic [31:0]       TO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] THR_HI_D = DATA_W'(THR_HI);
  localparam logic [DATA_W-1:0] THR_LO_D = DATA_W'(THR_LO);
  localparam logic [ZW-1:0]     ZONE_MAX = ZW'(N_ZONES - 1);

  state_t        state, state_next;
  logic [31:0]   cnt, cnt_next;
  logic [ZW-1:0] zone_next;
  logic [ZW-1:0] last_zone, last_next;
  logic          have_last, have_last_next;
  logic [ZW-1:0] start_zone;
  logic          arb_found;
  logic [ZW-1:0] arb_zone;
  logic [31:0]   dur;

  // Before anything has been served the search starts at zone 0.
  assign start_zone = !have_last            ? '0 :
                      (last_zone == ZONE_MAX) ? '0 : last_zone + ZW'(1);

  zone_rr_arbiter #(
    .N_ZONES(N_ZONES),
    .ZW     (ZW)
  ) u_arb (
    .enable(zone_enable),
    .start (start_zone),
    .found (arb_found),
    .zone  (arb_zone)
  );

  always_comb begin
    if (sample_data >= THR_HI_D)      dur = DUR_HI;
    else if (sample_data >= THR_LO_D) dur = DUR_LO;
    else                              dur = '0;
  end

  // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      zone_sel  <= '0;
      last_zone <= '0;
      have_last <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      zone_sel  <= zone_next;
      last_zone <= last_next;
      have_last <= have_last_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    zone_next      = zone_sel;
    last_next      = last_zone;
    have_last_next = have_last;
    timeout_pulse  = 1'b0;
    case (state)
      IDLE: if (|zone_enable) state_next = SCAN;
      SCAN: begin
        if (arb_found) begin
          zone_next  = arb_zone;
          cnt_next   = '0;
          state_next = REQ;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (sample_valid) begin
          cnt_next   = dur;
          state_next = (dur != '0) ? RUN : ADV;
        end else if (cnt == TO_LAST) begin
          timeout_pulse = 1'b1;
          state_next    = ADV;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      RUN: begin
        cnt_next = cnt - 32'd1;
        if (!zone_enable[zone_sel] || cnt == 32'd1) state_next = ADV;
      end
      ADV: begin
        last_next      = zone_sel;
        have_last_next = 1'b1;
        state_next     = SCAN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so reset closes the valve at once.
  always_comb begin
    valve = '0;
    if (state == RUN) valve[zone_sel] = 1'b1;
  end

  assign sample_req = (state == REQ);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_multizone_irrigation_ctrl.sv
// Directed bench for multizone_irrigation_ctrl with CLK_HZ=10, TIMEOUT_CYC=20:
// long/short/zero irrigation, skip, timeout, enable drop, async reset, stray valids.
module tb_multizone_irrigation_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  zone_enable = '0;
  logic [11:0] sample_data = '0;
  logic        sample_valid = 1'b0;
  logic        sample_req;
  logic [1:0]  zone_sel;
  logic [3:0]  valve;
  logic        busy;
  logic        timeout_pulse;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  valve_seen = '0;
  int          n;

  always #5 clk = ~clk;

  multizone_irrigation_ctrl #(
    .N_ZONES    (4),
    .DATA_W     (12),
    .CLK_HZ     (10),
    .THR_HI     (12),
    .THR_LO     (8),
    .T_HI_S     (10),
    .T_LO_S     (5),
    .TIMEOUT_CYC(20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .zone_enable  (zone_enable),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_req   (sample_req),
    .zone_sel     (zone_sel),
    .valve        (valve),
    .busy         (busy),
    .timeout_pulse(timeout_pulse)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    valve_seen |= valve;
    if ($countones(valve) > 1) check("valve_onehot", 32'($countones(valve)), 32'd1);
  endtask

  task automatic apply_reset(input logic [3:0] en);
    reset       = 1'b1;
    zone_enable = en;
    tick();
    tick();
    reset      = 1'b0;
    valve_seen = '0;
  endtask

  task automatic wait_req(input string tag, input logic [1:0] exp_zone);
    int k = 0;
    while (!sample_req && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_req_seen"}, 32'(sample_req), 32'd1);
    check({tag, "_zone"}, 32'(zone_sel), 32'(exp_zone));
  endtask

  task automatic give_sample(input logic [11:0] d);
    sample_data  = d;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  // Counts consecutive cycles with valve == exp_v; optionally changes the
  // enable mask at cycle clear_at and pokes stray sample_valid pulses.
  task automatic run_count(input logic [3:0] exp_v, input int clear_at,
                           input logic [3:0] new_en, input bit poke, output int cnt);
    cnt = 0;
    while (valve == exp_v && cnt < 400) begin
      cnt++;
      if (cnt == clear_at) zone_enable = new_en;
      sample_data  = 12'd15;
      sample_valid = poke && (cnt % 10 == 0);
      tick();
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_valve", 32'(valve), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(sample_req), 32'd0);
    check("rst_zone", 32'(zone_sel), 32'd0);
    check("rst_timeout", 32'(timeout_pulse), 32'd0);

    // Single zone, long irrigation: 10 s * 10 Hz = 100 cycles
    apply_reset(4'b0001);
    wait_req("s1_first", 2'd0);
    give_sample(12'd15);
    check("s1_busy_run", 32'(busy), 32'd1);
    run_count(4'b0001, 0, 4'b0000, 1'b0, n);
    check("s1_valve_cycles", 32'(n), 32'd100);
    wait_req("s1_again", 2'd0);

    // Zones 1 and 3: short irrigation, then zero duration, then wrap to 1
    apply_reset(4'b1010);
    wait_req("s2_z1", 2'd1);
    give_sample(12'd9);
    run_count(4'b0010, 0, 4'b0000, 1'b0, n);
    check("s2_valve_cycles", 32'(n), 32'd50);
    wait_req("s2_z3", 2'd3);
    give_sample(12'd3);
    check("s2_z3_valve", 32'(valve), 32'd0);
    wait_req("s2_wrap", 2'd1);
    check("s2_valve_seen", 32'(valve_seen), 32'b0010);

    // No sample: timeout on REQ cycle 20, then re-request
    apply_reset(4'b0100);
    wait_req("s3_z2", 2'd2);
    n = 1;
    while (!timeout_pulse && n < 40) begin
      tick();
      n++;
    end
    check("s3_timeout_cycle", 32'(n), 32'd20);
    tick();
    check("s3_pulse_width", 32'(timeout_pulse), 32'd0);
    check("s3_req_dropped", 32'(sample_req), 32'd0);
    wait_req("s3_rereq", 2'd2);
    check("s3_valve_seen", 32'(valve_seen), 32'd0);

    // Enable dropped at valve cycle 30 of a 100-cycle run
    apply_reset(4'b0011);
    wait_req("s4_z0", 2'd0);
    give_sample(12'd12);
    run_count(4'b0001, 30, 4'b0010, 1'b0, n);
    check("s4_valve_cycles", 32'(n), 32'd30);
    check("s4_valve_closed", 32'(valve), 32'd0);
    wait_req("s4_next", 2'd1);

    // Async reset mid-run; round-robin pointer must restart from zone 0
    apply_reset(4'b0011);
    wait_req("s5_z0", 2'd0);
    give_sample(12'd3);
    wait_req("s5_z1", 2'd1);
    give_sample(12'd15);
    check("s5_running", 32'(valve), 32'b0010);
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    check("s5_async_valve", 32'(valve), 32'd0);
    check("s5_async_busy", 32'(busy), 32'd0);
    check("s5_async_req", 32'(sample_req), 32'd0);
    check("s5_async_zone", 32'(zone_sel), 32'd0);
    tick();
    reset = 1'b0;
    wait_req("s5_after", 2'd0);

    // Stray sample_valid in IDLE and RUN; threshold boundaries 8 and 7
    apply_reset(4'b0000);
    sample_data  = 12'd15;
    sample_valid = 1'b1;
    repeat (3) tick();
    check("s6_idle_busy", 32'(busy), 32'd0);
    check("s6_idle_req", 32'(sample_req), 32'd0);
    check("s6_idle_valve", 32'(valve), 32'd0);
    sample_valid = 1'b0;
    zone_enable  = 4'b0001;
    wait_req("s6_z0", 2'd0);
    give_sample(12'd8);
    run_count(4'b0001, 0, 4'b0000, 1'b1, n);
    check("s6_valve_cycles", 32'(n), 32'd50);
    wait_req("s6_z0_b", 2'd0);
    valve_seen = '0;
    give_sample(12'd7);
    check("s6_below_lo_valve", 32'(valve), 32'd0);
    wait_req("s6_z0_c", 2'd0);
    check("s6_valve_seen", 32'(valve_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
